// File: rtl/rvfi_order_seq_pkg.sv
// Shared types for the RVFI reorder sequencer: buffered record, FSM state,
// and per-channel acceptance class.
package rvfi_order_seq_pkg;

  localparam int REC_XLEN = 32;

  typedef struct packed {
    logic [63:0]          order;
    logic                 trap;
    logic [4:0]           rd_addr;
    logic [REC_XLEN-1:0]  rd_wdata;
    logic [4:0]           rs1_addr;
    logic [REC_XLEN-1:0]  rs1_rdata;
    logic [4:0]           rs2_addr;
    logic [REC_XLEN-1:0]  rs2_rdata;
  } rec_t;

  typedef enum logic [1:0] {EMPTY, ACTIVE, HALT} state_e;

  typedef enum logic [1:0] {ACC_OK, ACC_STALE, ACC_OVERFLOW, ACC_DUP} acc_e;

endpackage

// File: rtl/rvfi_order_window_classify.sv
// Classifies one channel's incoming order against the reorder window,
// the occupied slots and same-cycle orders on lower-indexed channels.
module rvfi_order_window_classify
  import rvfi_order_seq_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int CH    = 0
) (
  input  logic [63:0]        order,
  input  logic [63:0]        next_order,
  input  logic [DEPTH-1:0]   slot_valid,
  input  logic [64*NRET-1:0] all_order,
  input  logic [NRET-1:0]    all_valid,
  output acc_e               acc
);

  localparam int IDXW = $clog2(DEPTH);

  logic [64:0] win_end;
  logic        lower_match;

  always_comb begin
    win_end     = {1'b0, next_order} + 65'(DEPTH);
    lower_match = 1'b0;
    // only channels below CH arbitrate against this one
    for (int k = 0; k < NRET; k++) begin
      if (k < CH && all_valid[k] && all_order[k*64 +: 64] == order)
        lower_match = 1'b1;
    end
    if (order < next_order)
      acc = ACC_STALE;
    else if ({1'b0, order} >= win_end)
      acc = ACC_OVERFLOW;
    else if (slot_valid[order[IDXW-1:0]] || lower_match)
      acc = ACC_DUP;
    else
      acc = ACC_OK;
  end

endmodule

// File: rtl/rvfi_order_sequencer.sv
// Reorders RVFI retirement records from NRET channels into strict rvfi_order
// sequence on a single valid/ready output; halts on any order-stream fault.
//
// state  | meaning
// EMPTY  | no buffered records, accepting
// ACTIVE | at least one record buffered, accepting and replaying
// HALT   | order fault seen; frozen until resetn
module rvfi_order_sequencer
  import rvfi_order_seq_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int XLEN  = REC_XLEN,
  parameter int DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NRET-1:0]             in_valid,
  input  logic [64*NRET-1:0]          in_order,
  input  logic [NRET-1:0]             in_trap,
  input  logic [5*NRET-1:0]           in_rd_addr,
  input  logic [XLEN*NRET-1:0]        in_rd_wdata,
  input  logic [5*NRET-1:0]           in_rs1_addr,
  input  logic [5*NRET-1:0]           in_rs2_addr,
  input  logic [XLEN*NRET-1:0]        in_rs1_rdata,
  input  logic [XLEN*NRET-1:0]        in_rs2_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [63:0]                 out_order,
  output logic                        out_trap,
  output logic [4:0]                  out_rd_addr,
  output logic [XLEN-1:0]             out_rd_wdata,
  output logic [4:0]                  out_rs1_addr,
  output logic [XLEN-1:0]             out_rs1_rdata,
  output logic [4:0]                  out_rs2_addr,
  output logic [XLEN-1:0]             out_rs2_rdata,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic                        err_stale,
  output logic                        err_overflow,
  output logic                        err_dup,
  output logic                        halted
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int OCCW = $clog2(DEPTH+1);

  rec_t             slot_q [DEPTH];
  logic [DEPTH-1:0] slot_vld_q;
  logic [63:0]      next_order_q;
  state_e           state_q;

  acc_e             acc [NRET];
  rec_t             in_rec [NRET];
  logic [NRET-1:0]  wr_en;
  logic             any_stale, any_ovf, any_dup, any_err;
  logic [DEPTH-1:0] set_mask, clr_mask, vld_next;
  logic [IDXW-1:0]  head_idx;
  rec_t             head_rec;
  logic             pop;

  for (genvar c = 0; c < NRET; c++) begin : g_cls
    rvfi_order_window_classify #(
      .NRET  (NRET),
      .DEPTH (DEPTH),
      .CH    (c)
    ) u_cls (
      .order      (in_order[c*64 +: 64]),
      .next_order (next_order_q),
      .slot_valid (slot_vld_q),
      .all_order  (in_order),
      .all_valid  (in_valid),
      .acc        (acc[c])
    );
  end

  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      in_rec[c].order     = in_order[c*64 +: 64];
      in_rec[c].trap      = in_trap[c];
      in_rec[c].rd_addr   = in_rd_addr[c*5 +: 5];
      in_rec[c].rd_wdata  = in_rd_wdata[c*XLEN +: XLEN];
      in_rec[c].rs1_addr  = in_rs1_addr[c*5 +: 5];
      in_rec[c].rs1_rdata = in_rs1_rdata[c*XLEN +: XLEN];
      in_rec[c].rs2_addr  = in_rs2_addr[c*5 +: 5];
      in_rec[c].rs2_rdata = in_rs2_rdata[c*XLEN +: XLEN];
    end
  end

  always_comb begin
    wr_en     = '0;
    any_stale = 1'b0;
    any_ovf   = 1'b0;
    any_dup   = 1'b0;
    set_mask  = '0;
    if (state_q != HALT) begin
      for (int c = 0; c < NRET; c++) begin
        if (in_valid[c]) begin
          case (acc[c])
            ACC_OK:       wr_en[c]  = 1'b1;
            ACC_STALE:    any_stale = 1'b1;
            ACC_OVERFLOW: any_ovf   = 1'b1;
            default:      any_dup   = 1'b1;
          endcase
        end
      end
      for (int c = 0; c < NRET; c++) begin
        if (wr_en[c]) set_mask[in_order[c*64 +: IDXW]] = 1'b1;
      end
    end
    any_err = any_stale | any_ovf | any_dup;
  end

  assign head_idx  = next_order_q[IDXW-1:0];
  assign head_rec  = slot_q[head_idx];
  assign out_valid = slot_vld_q[head_idx] && (state_q != HALT);
  assign pop       = out_valid && out_ready;

  // a write can never target the head slot while it is still valid (dup),
  // so set and clear never collide
  always_comb begin
    clr_mask           = '0;
    clr_mask[head_idx] = pop;
    vld_next           = (slot_vld_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCCW'(slot_vld_q[i]);
  end

  assign out_order     = head_rec.order;
  assign out_trap      = head_rec.trap;
  assign out_rd_addr   = head_rec.rd_addr;
  assign out_rd_wdata  = head_rec.rd_wdata;
  assign out_rs1_addr  = head_rec.rs1_addr;
  assign out_rs1_rdata = head_rec.rs1_rdata;
  assign out_rs2_addr  = head_rec.rs2_addr;
  assign out_rs2_rdata = head_rec.rs2_rdata;

  always_ff @(posedge clock) begin
    for (int c = 0; c < NRET; c++) begin
      if (wr_en[c]) slot_q[in_order[c*64 +: IDXW]] <= in_rec[c];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= EMPTY;
      slot_vld_q   <= '0;
      next_order_q <= '0;
      err_stale    <= 1'b0;
      err_overflow <= 1'b0;
      err_dup      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state_q)
        EMPTY, ACTIVE: begin
          slot_vld_q <= vld_next;
          if (pop) next_order_q <= next_order_q + 64'd1;
          if (any_stale) err_stale    <= 1'b1;
          if (any_ovf)   err_overflow <= 1'b1;
          if (any_dup)   err_dup      <= 1'b1;
          if (any_err) begin
            state_q <= HALT;
            halted  <= 1'b1;
          end else if (|vld_next) begin
            state_q <= ACTIVE;
          end else begin
            state_q <= EMPTY;
          end
        end
        HALT: ;
        default: begin
          state_q <= HALT;
          halted  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_order_sequencer.sv
// Directed table-driven bench for rvfi_order_sequencer plus hand-written
// sequences for backpressure, faults, async reset and field passthrough.
module tb_rvfi_order_sequencer;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic [NRET-1:0]      in_valid = '0;
  logic [64*NRET-1:0]   in_order = '0;
  logic [NRET-1:0]      in_trap = '0;
  logic [5*NRET-1:0]    in_rd_addr = '0, in_rs1_addr = '0, in_rs2_addr = '0;
  logic [XLEN*NRET-1:0] in_rd_wdata = '0, in_rs1_rdata = '0, in_rs2_rdata = '0;
  logic                 out_ready = 1'b0;
  logic                 out_valid, out_trap;
  logic [63:0]          out_order;
  logic [4:0]           out_rd_addr, out_rs1_addr, out_rs2_addr;
  logic [XLEN-1:0]      out_rd_wdata, out_rs1_rdata, out_rs2_rdata;
  logic [3:0]           occupancy;
  logic                 err_stale, err_overflow, err_dup, halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  rvfi_order_sequencer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_order(in_order), .in_trap(in_trap),
    .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_trap(out_trap), .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
    .out_rs1_addr(out_rs1_addr), .out_rs1_rdata(out_rs1_rdata),
    .out_rs2_addr(out_rs2_addr), .out_rs2_rdata(out_rs2_rdata),
    .occupancy(occupancy), .err_stale(err_stale), .err_overflow(err_overflow),
    .err_dup(err_dup), .halted(halted)
  );

  typedef struct {
    logic        v0;
    logic [63:0] o0;
    logic        v1;
    logic [63:0] o1;
    logic        rdy;
    logic        e_valid;
    logic [63:0] e_order;
    int          e_occ;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic v0, input int o0, input logic v1, input int o1,
                              input logic rdy, input logic ev, input int eo, input int eocc);
    vec_t r;
    r.v0 = v0; r.o0 = 64'(o0); r.v1 = v1; r.o1 = 64'(o1); r.rdy = rdy;
    r.e_valid = ev; r.e_order = 64'(eo); r.e_occ = eocc;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic ev, input int occ,
                              input logic es, input logic eo, input logic ed, input logic eh);
    check({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, " occupancy"}, 64'(occupancy), 64'(occ));
    check({tag, " err_stale"}, 64'(err_stale), 64'(es));
    check({tag, " err_overflow"}, 64'(err_overflow), 64'(eo));
    check({tag, " err_dup"}, 64'(err_dup), 64'(ed));
    check({tag, " halted"}, 64'(halted), 64'(eh));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    in_valid = '0;
    in_trap  = '0;
  endtask

  task automatic push(input int ch, input int ord, input logic rdy);
    in_valid[ch] = 1'b1;
    in_order[ch*64 +: 64] = 64'(ord);
    out_ready = rdy;
    step();
  endtask

  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    resetn    = 1'b0;
    #2;
    resetn    = 1'b1;
  endtask

  initial begin
    // in-order stream, then reordered dual retire, then a gap that fills late
    vecs[0]  = mk(1, 0, 0, 0, 1, 1, 0, 1);
    vecs[1]  = mk(1, 1, 0, 0, 1, 1, 1, 1);
    vecs[2]  = mk(1, 2, 0, 0, 1, 1, 2, 1);
    vecs[3]  = mk(1, 3, 0, 0, 1, 1, 3, 1);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(1, 5, 1, 4, 1, 1, 4, 2);
    vecs[6]  = mk(0, 0, 0, 0, 1, 1, 5, 1);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 8, 0, 0, 1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 1, 6, 1, 1, 6, 2);
    vecs[10] = mk(1, 7, 0, 0, 1, 1, 7, 2);
    vecs[11] = mk(0, 0, 0, 0, 1, 1, 8, 1);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    check_status("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      in_valid = {vecs[i].v1, vecs[i].v0};
      in_order = {vecs[i].o1, vecs[i].o0};
      out_ready = vecs[i].rdy;
      step();
      check_status($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_occ,
                   1'b0, 1'b0, 1'b0, 1'b0);
      if (vecs[i].e_valid) check($sformatf("vec%0d out_order", i), out_order, vecs[i].e_order);
    end

    // backpressure fill, head held, then overflow at next_order+DEPTH
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push(i % 2, i, 1'b0);
      check($sformatf("bp%0d out_order", i), out_order, 64'd0);
      check($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
    end
    check("bp full occupancy", 64'(occupancy), 64'd8);
    push(0, 8, 1'b0);
    check_status("bp ovf", 1'b0, 8, 1'b0, 1'b1, 1'b0, 1'b1);

    // pop and write into the freed slot on the same edge: still overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(0, i, 1'b0);
    push(1, 8, 1'b1);
    check_status("popwr ovf", 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b1);

    // stale after draining 0..2, then nothing accepted in HALT
    do_reset();
    push(0, 0, 1'b1);
    push(0, 1, 1'b1);
    push(0, 2, 1'b1);
    out_ready = 1'b1;
    step();
    check_status("drain", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(0, 1, 1'b1);
    check_status("stale", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(0, 3, 1'b1);
    check_status("halt ignore", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // same order on both channels: ch0 kept, ch1 flagged
    do_reset();
    in_valid = 2'b11;
    in_order = {64'd5, 64'd5};
    out_ready = 1'b0;
    step();
    check_status("dup same cycle", 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b1);

    // order already buffered
    do_reset();
    push(0, 3, 1'b0);
    push(1, 3, 1'b0);
    check_status("dup buffered", 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b1);

    // async reset between edges discards state immediately
    do_reset();
    push(0, 0, 1'b0);
    push(1, 1, 1'b0);
    push(0, 2, 1'b0);
    check_status("pre ovf", 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(0, 9, 1'b0);
    check_status("pre reset", 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    check_status("async reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    push(0, 0, 1'b0);
    check_status("post reset", 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post reset out_order", out_order, 64'd0);

    // field passthrough on both channels, trap on ch0
    do_reset();
    in_trap[0]           = 1'b1;
    in_rd_addr[4:0]      = 5'd5;
    in_rd_wdata[31:0]    = 32'hdeadbeef;
    in_rs1_addr[4:0]     = 5'd3;
    in_rs1_rdata[31:0]   = 32'h11112222;
    in_rs2_addr[4:0]     = 5'd4;
    in_rs2_rdata[31:0]   = 32'h33334444;
    in_rd_addr[9:5]      = 5'd17;
    in_rd_wdata[63:32]   = 32'h12345678;
    in_rs1_addr[9:5]     = 5'd8;
    in_rs1_rdata[63:32]  = 32'h55556666;
    in_rs2_addr[9:5]     = 5'd9;
    in_rs2_rdata[63:32]  = 32'h77778888;
    in_valid = 2'b11;
    in_order = {64'd1, 64'd0};
    out_ready = 1'b0;
    step();
    check("trap out_valid", 64'(out_valid), 64'd1);
    check("trap out_order", out_order, 64'd0);
    check("trap out_trap", 64'(out_trap), 64'd1);
    check("trap rd_addr", 64'(out_rd_addr), 64'd5);
    check("trap rd_wdata", 64'(out_rd_wdata), 64'hdeadbeef);
    check("trap rs1_addr", 64'(out_rs1_addr), 64'd3);
    check("trap rs1_rdata", 64'(out_rs1_rdata), 64'h11112222);
    check("trap rs2_addr", 64'(out_rs2_addr), 64'd4);
    check("trap rs2_rdata", 64'(out_rs2_rdata), 64'h33334444);
    out_ready = 1'b1;
    step();
    check("ch1 out_valid", 64'(out_valid), 64'd1);
    check("ch1 out_order", out_order, 64'd1);
    check("ch1 out_trap", 64'(out_trap), 64'd0);
    check("ch1 rd_addr", 64'(out_rd_addr), 64'd17);
    check("ch1 rd_wdata", 64'(out_rd_wdata), 64'h12345678);
    check("ch1 rs1_addr", 64'(out_rs1_addr), 64'd8);
    check("ch1 rs1_rdata", 64'(out_rs1_rdata), 64'h55556666);
    check("ch1 rs2_addr", 64'(out_rs2_addr), 64'd9);
    check("ch1 rs2_rdata", 64'(out_rs2_rdata), 64'h77778888);
    step();
    check_status("trap drained", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
